// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the 5-stage pipeline: fetch FSM states, the
// canonical NOP and instruction width, plus a small alignment helper.
package rv_pipe_pkg;

  localparam int unsigned INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [INSTR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// 8-bit wait counter with synchronous clear and a terminal flag that fires
// in the counted cycle that brings the count up to limit_i.
module fetch_timeout_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [7:0] limit_i,
  output logic       tc_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins, otherwise a saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturation keeps the compare monotonic even if a cycle is skipped.
  assign tc_o = inc_i && (({1'b0, cnt_q} + 9'd1) >= {1'b0, limit_i});

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the external PC register, runs the
// req/ack handshake to instruction memory and loads the IF/ID register,
// with stall hold, redirect/flush and fault (misaligned / timeout) handling.
module fetch_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] pc_cur,
  output logic               pc_enable,
  output logic [INSTR_W-1:0] pc_next,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               hazard_stall,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_target,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [INSTR_W-1:0] ifid_pc,
  output logic               ifid_flush,
  output logic               fetch_fault,
  output logic [INSTR_W-1:0] fault_addr
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] addr_q;
  logic               kill_q;
  logic [INSTR_W-1:0] hold_instr_q;
  logic [INSTR_W-1:0] hold_pc_q;
  logic               ifid_valid_q;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic [INSTR_W-1:0] ifid_pc_q;
  logic               ifid_flush_q;
  logic               fetch_fault_q;
  logic [INSTR_W-1:0] fault_addr_q;

  logic               fetching;
  logic               redir_ok;
  logic               redir_bad;
  logic               take;
  logic [INSTR_W-1:0] fetch_addr;
  logic               wait_inc;
  logic               timeout_hit;

  // Request/PC decode from current state and inputs.
  always_comb begin
    fetching  = (state_q == ST_REQ) || (state_q == ST_WAIT);
    redir_ok  = (state_q != ST_FAULT) && redirect_valid && is_word_aligned(redirect_target);
    redir_bad = (state_q != ST_FAULT) && redirect_valid && !is_word_aligned(redirect_target);
    // An ack is only accepted when nothing squashes it.
    take      = fetching && imem_ack && !redirect_valid && !kill_q;
    wait_inc  = (state_q == ST_WAIT) && !imem_ack;
    if (state_q == ST_WAIT) begin
      fetch_addr = addr_q;
    end else begin
      fetch_addr = pc_cur;
    end
    if (redir_ok) begin
      pc_next = redirect_target;
    end else begin
      pc_next = fetch_addr + 32'd4;
    end
    pc_enable = redir_ok || take;
  end

  assign imem_req  = fetching;
  assign imem_addr = fetch_addr;

  fetch_timeout_ctr u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (!wait_inc),
    .inc_i   (wait_inc),
    .limit_i (TO_LIMIT),
    .tc_o    (timeout_hit)
  );

  // Fetch FSM with registered IF/ID and fault outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= 32'd0;
      kill_q        <= 1'b0;
      hold_instr_q  <= NOP_INSTR;
      hold_pc_q     <= 32'd0;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc_q     <= 32'd0;
      ifid_flush_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_addr_q  <= 32'd0;
    end else begin
      ifid_flush_q <= 1'b0;
      if (state_q == ST_FAULT) begin
        state_q <= ST_FAULT;
      end else begin
        // Decode consumed the current entry unless it is stalled.
        if (!hazard_stall) begin
          ifid_valid_q <= 1'b0;
        end
        if (state_q == ST_REQ) begin
          addr_q <= pc_cur;
        end
        if (redir_bad) begin
          state_q       <= ST_FAULT;
          fetch_fault_q <= 1'b1;
          fault_addr_q  <= redirect_target;
        end else if (redir_ok) begin
          ifid_flush_q <= 1'b1;
          ifid_valid_q <= 1'b0;
          // An outstanding request must still be retired before refetching.
          if ((state_q == ST_WAIT) && !imem_ack) begin
            kill_q  <= 1'b1;
            state_q <= ST_WAIT;
          end else begin
            kill_q  <= 1'b0;
            state_q <= ST_REQ;
          end
        end else begin
          case (state_q)
            ST_IDLE: state_q <= ST_REQ;
            ST_REQ, ST_WAIT: begin
              if (imem_ack) begin
                if (kill_q) begin
                  kill_q  <= 1'b0;
                  state_q <= ST_REQ;
                end else if (hazard_stall) begin
                  hold_instr_q <= imem_rdata;
                  hold_pc_q    <= fetch_addr;
                  state_q      <= ST_HOLD;
                end else begin
                  ifid_valid_q <= 1'b1;
                  ifid_instr_q <= imem_rdata;
                  ifid_pc_q    <= fetch_addr;
                  state_q      <= ST_REQ;
                end
              end else if (state_q == ST_REQ) begin
                state_q <= ST_WAIT;
              end else if (timeout_hit) begin
                state_q       <= ST_FAULT;
                fetch_fault_q <= 1'b1;
                fault_addr_q  <= addr_q;
              end else begin
                state_q <= ST_WAIT;
              end
            end
            ST_HOLD: begin
              if (!hazard_stall) begin
                ifid_valid_q <= 1'b1;
                ifid_instr_q <= hold_instr_q;
                ifid_pc_q    <= hold_pc_q;
                state_q      <= ST_REQ;
              end else begin
                state_q <= ST_HOLD;
              end
            end
            default: begin
              state_q       <= ST_FAULT;
              fetch_fault_q <= 1'b1;
              fault_addr_q  <= addr_q;
            end
          endcase
        end
      end
    end
  end

  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_flush  = ifid_flush_q;
  assign fetch_fault = fetch_fault_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written
// fault sequences, and randomized traffic against a transaction-level model.
module tb_fetch_ctrl;

  localparam int T = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A   = 32'hAAAA_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic        pc_enable;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_flush;
  logic        fetch_fault;
  logic [31:0] fault_addr;

  fetch_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_enable(pc_enable), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .hazard_stall(hazard_stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_flush(ifid_flush),
    .fetch_fault(fetch_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  // External PC register.
  always @(posedge clk or posedge reset) begin
    if (reset) pc_cur <= 32'd0;
    else if (pc_enable) pc_cur <= pc_next;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic a, input logic [31:0] d, input logic s,
                       input logic r, input logic [31:0] t);
    @(negedge clk);
    imem_ack = a; imem_rdata = d; hazard_stall = s;
    redirect_valid = r; redirect_target = t;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; hazard_stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'd0;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  typedef struct {
    logic ack; logic [31:0] rdata; logic stall; logic redir; logic [31:0] tgt;
    logic e_req; logic [31:0] e_addr; logic e_en; logic [31:0] e_next;
    logic e_valid; logic [31:0] e_pc; logic [31:0] e_instr; logic e_flush;
  } vec_t;
  vec_t tbl[$];

  // Reference model: fetch progress as plain bookkeeping.
  bit          m_started, m_waiting, m_drop, m_held, m_dead;
  int          m_waited;
  logic [31:0] m_wait_addr, m_held_instr, m_held_pc, m_pcreg;
  logic        m_valid, m_flush, m_fault;
  logic [31:0] m_instr, m_pc, m_faddr;

  task automatic model_reset();
    m_started = 0; m_waiting = 0; m_drop = 0; m_held = 0; m_dead = 0; m_waited = 0;
    m_wait_addr = 0; m_held_instr = NOP; m_held_pc = 0; m_pcreg = 0;
    m_valid = 0; m_flush = 0; m_fault = 0; m_instr = NOP; m_pc = 0; m_faddr = 0;
  endtask

  logic        r_ack, r_stall, r_redir, e_req, e_bad, e_good, e_acc, e_en;
  logic [31:0] r_data, r_tgt, e_addr, e_next;

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; hazard_stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'd0;
    #1;
    chk("rst_req", imem_req, 0);        chk("rst_pc_en", pc_enable, 0);
    chk("rst_valid", ifid_valid, 0);    chk("rst_instr", ifid_instr, NOP);
    chk("rst_pc", ifid_pc, 0);          chk("rst_flush", ifid_flush, 0);
    chk("rst_fault", fetch_fault, 0);   chk("rst_faddr", fault_addr, 0);

    // ---------------- directed vector table ----------------
    tbl.push_back('{0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   NOP,       0});
    tbl.push_back('{1, A+32'h0,      0, 0, 32'h0,   1, 32'h0,   1, 32'h4,   0, 32'h0,   NOP,       0});
    tbl.push_back('{1, A+32'h4,      0, 0, 32'h0,   1, 32'h4,   1, 32'h8,   1, 32'h0,   A,         0});
    tbl.push_back('{1, A+32'h8,      1, 0, 32'h0,   1, 32'h8,   1, 32'hC,   1, 32'h4,   A+32'h4,   0});
    tbl.push_back('{0, 32'h0,        1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h4,   A+32'h4,   0});
    tbl.push_back('{0, 32'h0,        1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h4,   A+32'h4,   0});
    tbl.push_back('{0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h4,   A+32'h4,   0});
    tbl.push_back('{1, A+32'hC,      0, 0, 32'h0,   1, 32'hC,   1, 32'h10,  1, 32'h8,   A+32'h8,   0});
    tbl.push_back('{0, 32'h0,        0, 0, 32'h0,   1, 32'h10,  0, 32'h0,   1, 32'hC,   A+32'hC,   0});
    tbl.push_back('{0, 32'h0,        0, 0, 32'h0,   1, 32'h10,  0, 32'h0,   0, 32'hC,   A+32'hC,   0});
    tbl.push_back('{0, 32'h0,        0, 0, 32'h0,   1, 32'h10,  0, 32'h0,   0, 32'hC,   A+32'hC,   0});
    tbl.push_back('{1, A+32'h10,     0, 0, 32'h0,   1, 32'h10,  1, 32'h14,  0, 32'hC,   A+32'hC,   0});
    tbl.push_back('{0, 32'h0,        0, 0, 32'h0,   1, 32'h14,  0, 32'h0,   1, 32'h10,  A+32'h10,  0});
    tbl.push_back('{0, 32'h0,        0, 1, 32'h200, 1, 32'h14,  1, 32'h200, 0, 32'h10,  A+32'h10,  0});
    tbl.push_back('{0, 32'h0,        0, 0, 32'h0,   1, 32'h14,  0, 32'h0,   0, 32'h10,  A+32'h10,  1});
    tbl.push_back('{1, 32'hDEAD0014, 0, 0, 32'h0,   1, 32'h14,  0, 32'h0,   0, 32'h10,  A+32'h10,  0});
    tbl.push_back('{1, A+32'h200,    0, 0, 32'h0,   1, 32'h200, 1, 32'h204, 0, 32'h10,  A+32'h10,  0});
    tbl.push_back('{1, 32'hBEEF0204, 0, 1, 32'h300, 1, 32'h204, 1, 32'h300, 1, 32'h200, A+32'h200, 0});
    tbl.push_back('{0, 32'h0,        0, 1, 32'h400, 1, 32'h300, 1, 32'h400, 0, 32'h200, A+32'h200, 1});
    tbl.push_back('{0, 32'h0,        0, 0, 32'h0,   1, 32'h400, 0, 32'h0,   0, 32'h200, A+32'h200, 1});
    tbl.push_back('{1, A+32'h400,    0, 0, 32'h0,   1, 32'h400, 1, 32'h404, 0, 32'h200, A+32'h200, 0});
    tbl.push_back('{0, 32'h0,        0, 0, 32'h0,   1, 32'h404, 0, 32'h0,   1, 32'h400, A+32'h400, 0});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ack, tbl[i].rdata, tbl[i].stall, tbl[i].redir, tbl[i].tgt);
      chk($sformatf("vec%0d_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_pc_en", i), pc_enable, tbl[i].e_en);
      if (tbl[i].e_en) chk($sformatf("vec%0d_pc_next", i), pc_next, tbl[i].e_next);
      chk($sformatf("vec%0d_valid", i), ifid_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_ifid_pc", i), ifid_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), ifid_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d_flush", i), ifid_flush, tbl[i].e_flush);
    end

    // ---------------- misaligned redirect ----------------
    do_reset();
    drive(0, 32'h0, 0, 0, 32'h0);
    drive(0, 32'h0, 0, 1, 32'h102);
    chk("mis_req", imem_req, 1);
    chk("mis_pc_en", pc_enable, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1, 32'h80);
      chk("mis_fault", fetch_fault, 1);
      chk("mis_faddr", fault_addr, 32'h102);
      chk("mis_req_off", imem_req, 0);
      chk("mis_pc_off", pc_enable, 0);
      chk("mis_no_flush", ifid_flush, 0);
      chk("mis_pc_kept", pc_cur, 32'h0);
    end
    do_reset();
    drive(0, 32'h0, 0, 0, 32'h0);
    chk("mis_clr_fault", fetch_fault, 0);
    chk("mis_clr_faddr", fault_addr, 0);

    // ---------------- memory timeout ----------------
    drive(0, 32'h0, 0, 1, 32'h40);
    chk("to_redir_en", pc_enable, 1);
    chk("to_redir_next", pc_next, 32'h40);
    drive(0, 32'h0, 0, 0, 32'h0);
    chk("to_req_addr", imem_addr, 32'h40);
    for (int k = 0; k < T; k++) begin
      drive(0, 32'h0, 0, 0, 32'h0);
      chk($sformatf("to_wait%0d_req", k), imem_req, 1);
      chk($sformatf("to_wait%0d_addr", k), imem_addr, 32'h40);
      chk($sformatf("to_wait%0d_fault", k), fetch_fault, 0);
    end
    drive(1, 32'h0, 0, 0, 32'h0);
    chk("to_fault", fetch_fault, 1);
    chk("to_faddr", fault_addr, 32'h40);
    chk("to_req_off", imem_req, 0);
    chk("to_pc_off", pc_enable, 0);

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      if ((m_dead && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 299) == 0)) begin
        do_reset();
        model_reset();
      end
      r_ack   = ($urandom_range(0, 99) < 60);
      r_data  = $urandom;
      r_stall = ($urandom_range(0, 99) < 25);
      r_redir = ($urandom_range(0, 99) < 8);
      r_tgt   = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 9) == 0) r_tgt[1:0] = 2'($urandom_range(1, 3));
      drive(r_ack, r_data, r_stall, r_redir, r_tgt);

      e_req  = m_started && !m_held && !m_dead;
      e_addr = m_waiting ? m_wait_addr : m_pcreg;
      e_bad  = r_redir && (r_tgt[1:0] != 2'b00) && !m_dead;
      e_good = r_redir && (r_tgt[1:0] == 2'b00) && !m_dead;
      e_acc  = e_req && r_ack && !r_redir && !m_drop;
      e_en   = e_good || e_acc;
      e_next = e_good ? r_tgt : e_addr + 32'd4;

      chk("rnd_pc_reg", pc_cur, m_pcreg);
      chk("rnd_req", imem_req, e_req);
      if (e_req) chk("rnd_addr", imem_addr, e_addr);
      chk("rnd_pc_en", pc_enable, e_en);
      if (e_en) chk("rnd_pc_next", pc_next, e_next);
      chk("rnd_valid", ifid_valid, m_valid);
      chk("rnd_ifid_pc", ifid_pc, m_pc);
      chk("rnd_instr", ifid_instr, m_instr);
      chk("rnd_flush", ifid_flush, m_flush);
      chk("rnd_fault", fetch_fault, m_fault);
      chk("rnd_faddr", fault_addr, m_faddr);

      if (e_en) m_pcreg = e_next;
      m_flush = 0;
      if (!m_dead) begin
        if (!r_stall) m_valid = 0;
        if (e_bad) begin
          m_dead = 1; m_fault = 1; m_faddr = r_tgt;
        end else if (e_good) begin
          m_flush = 1; m_valid = 0; m_held = 0; m_started = 1;
          if (e_req && m_waiting && !r_ack) begin
            m_drop = 1; m_waited++;
          end else begin
            m_waiting = 0; m_drop = 0; m_waited = 0;
          end
        end else if (!m_started) begin
          m_started = 1;
        end else if (m_held) begin
          if (!r_stall) begin
            m_valid = 1; m_instr = m_held_instr; m_pc = m_held_pc; m_held = 0;
          end
        end else if (r_ack) begin
          m_waiting = 0; m_waited = 0;
          if (m_drop) m_drop = 0;
          else if (r_stall) begin
            m_held = 1; m_held_instr = r_data; m_held_pc = e_addr;
          end else begin
            m_valid = 1; m_instr = r_data; m_pc = e_addr;
          end
        end else if (m_waiting) begin
          if (m_waited + 1 >= T) begin
            m_dead = 1; m_fault = 1; m_faddr = m_wait_addr;
          end else m_waited++;
        end else begin
          m_waiting = 1; m_wait_addr = e_addr; m_waited = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
